sc_reglanebank: RTL and testbench

SC_REGLANEBANK -- requirements
Module: sc_reglanebank

---
 rtl/sc_reglanebank_if.sv | 41 ++++
 rtl/sc_reglanebank.sv | 89 ++++++++
 tb/tb_sc_reglanebank.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_reglanebank_if.sv
// Bus bundle for the rotating lane register bank: control/config inputs and lane outputs.
interface sc_reglanebank_if #(
    parameter int RegLANEBANK_DATAWIDTH    = 8,
    parameter int RegLANEBANK_LANES        = 4,
    parameter int RegLANEBANK_LANESELWIDTH = 2,
    parameter int RegLANEBANK_SPEEDWIDTH   = 4
);
    logic                                                     SC_RegLANEBANK_clear_InLow;
    logic                                                     SC_RegLANEBANK_load_InLow;
    logic [RegLANEBANK_LANESELWIDTH-1:0]                      SC_RegLANEBANK_laneselect_In;
    logic [RegLANEBANK_DATAWIDTH-1:0]                         SC_RegLANEBANK_data_InBUS;
    logic                                                     SC_RegLANEBANK_enable_In;
    logic [RegLANEBANK_LANES-1:0]                             SC_RegLANEBANK_direction_In;
    logic [RegLANEBANK_LANES*RegLANEBANK_SPEEDWIDTH-1:0]      SC_RegLANEBANK_period_InBUS;
    logic [RegLANEBANK_LANES*RegLANEBANK_DATAWIDTH-1:0]       SC_RegLANEBANK_data_OutBUS;
    logic [RegLANEBANK_LANES-1:0]                             SC_RegLANEBANK_stepped_Out;

    modport master (
        output SC_RegLANEBANK_clear_InLow,
        output SC_RegLANEBANK_load_InLow,
        output SC_RegLANEBANK_laneselect_In,
        output SC_RegLANEBANK_data_InBUS,
        output SC_RegLANEBANK_enable_In,
        output SC_RegLANEBANK_direction_In,
        output SC_RegLANEBANK_period_InBUS,
        input  SC_RegLANEBANK_data_OutBUS,
        input  SC_RegLANEBANK_stepped_Out
    );

    modport slave (
        input  SC_RegLANEBANK_clear_InLow,
        input  SC_RegLANEBANK_load_InLow,
        input  SC_RegLANEBANK_laneselect_In,
        input  SC_RegLANEBANK_data_InBUS,
        input  SC_RegLANEBANK_enable_In,
        input  SC_RegLANEBANK_direction_In,
        input  SC_RegLANEBANK_period_InBUS,
        output SC_RegLANEBANK_data_OutBUS,
        output SC_RegLANEBANK_stepped_Out
    );
endinterface

// File: rtl/sc_reglanebank.sv
// Bank of independent rotating lane registers, each stepped every P enable ticks.
module sc_reglanebank #(
    parameter int RegLANEBANK_DATAWIDTH    = 8,
    parameter int RegLANEBANK_LANES        = 4,
    parameter int RegLANEBANK_LANESELWIDTH = 2,
    parameter int RegLANEBANK_SPEEDWIDTH   = 4,
    parameter logic [RegLANEBANK_DATAWIDTH-1:0] DATA_FIXED_INITREGLANE = '0
) (
    input  logic             SC_RegLANEBANK_CLOCK_50,
    input  logic             SC_RegLANEBANK_RESET_InHigh,
    sc_reglanebank_if.slave  bus
);
    localparam int DW = RegLANEBANK_DATAWIDTH;
    localparam int NL = RegLANEBANK_LANES;
    localparam int SW = RegLANEBANK_SPEEDWIDTH;

    logic [DW-1:0]      r_lane     [NL];
    logic [SW-1:0]      r_cnt      [NL];
    logic [NL-1:0]      r_stepped;

    logic [DW-1:0]      w_lane_nxt [NL];
    logic [SW-1:0]      w_cnt_nxt  [NL];
    logic [SW-1:0]      w_period   [NL];
    logic [NL-1:0]      w_step_nxt;
    logic [NL*DW-1:0]   w_data_flat;

    // Bitwise rotate so a 1-bit lane degenerates to identity without special slicing.
    function automatic logic [DW-1:0] f_rotate(input logic [DW-1:0] x, input logic right);
        logic [DW-1:0] y;
        y = '0;
        for (int b = 0; b < DW; b++) begin
            if (right) y[b] = x[(b + 1) % DW];
            else       y[b] = x[(b + DW - 1) % DW];
        end
        return y;
    endfunction

    always_comb begin
        w_step_nxt = '0;
        for (int i = 0; i < NL; i++) begin
            w_lane_nxt[i] = r_lane[i];
            w_cnt_nxt[i]  = r_cnt[i];
            w_period[i]   = bus.SC_RegLANEBANK_period_InBUS[i*SW +: SW];
            if (!bus.SC_RegLANEBANK_clear_InLow) begin
                w_lane_nxt[i] = DATA_FIXED_INITREGLANE;
                w_cnt_nxt[i]  = '0;
            end else if (!bus.SC_RegLANEBANK_load_InLow &&
                         (32'(bus.SC_RegLANEBANK_laneselect_In) == i)) begin
                w_lane_nxt[i] = bus.SC_RegLANEBANK_data_InBUS;
                w_cnt_nxt[i]  = '0;
            end else if (bus.SC_RegLANEBANK_enable_In && (w_period[i] != '0)) begin
                // >= rather than == so a shrinking period fires immediately instead of wrapping.
                if (r_cnt[i] >= (w_period[i] - SW'(1))) begin
                    w_lane_nxt[i] = f_rotate(r_lane[i], bus.SC_RegLANEBANK_direction_In[i]);
                    w_cnt_nxt[i]  = '0;
                    w_step_nxt[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i]  = r_cnt[i] + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge SC_RegLANEBANK_CLOCK_50) begin
        if (SC_RegLANEBANK_RESET_InHigh) begin
            for (int i = 0; i < NL; i++) begin
                r_lane[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_stepped <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                r_lane[i] <= w_lane_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
            end
            r_stepped <= w_step_nxt;
        end
    end

    always_comb begin
        w_data_flat = '0;
        for (int i = 0; i < NL; i++) begin
            w_data_flat[i*DW +: DW] = r_lane[i];
        end
    end

    assign bus.SC_RegLANEBANK_data_OutBUS = w_data_flat;
    assign bus.SC_RegLANEBANK_stepped_Out = r_stepped;
endmodule

// File: tb/tb_sc_reglanebank.sv
// Directed bench for sc_reglanebank: rotation timing, freeze, period shrink, priorities, reset.
module tb_sc_reglanebank;
    localparam logic [7:0] INIT = 8'hA5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sc_reglanebank_if #(
        .RegLANEBANK_DATAWIDTH(8), .RegLANEBANK_LANES(4),
        .RegLANEBANK_LANESELWIDTH(2), .RegLANEBANK_SPEEDWIDTH(4)
    ) bus ();

    sc_reglanebank #(
        .RegLANEBANK_DATAWIDTH(8), .RegLANEBANK_LANES(4),
        .RegLANEBANK_LANESELWIDTH(2), .RegLANEBANK_SPEEDWIDTH(4),
        .DATA_FIXED_INITREGLANE(INIT)
    ) dut (
        .SC_RegLANEBANK_CLOCK_50    (clk),
        .SC_RegLANEBANK_RESET_InHigh(rst),
        .bus                        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int i);
        return bus.SC_RegLANEBANK_data_OutBUS[i*8 +: 8];
    endfunction

    task automatic load_lane(input logic [1:0] sel, input logic [7:0] d);
        bus.SC_RegLANEBANK_laneselect_In = sel;
        bus.SC_RegLANEBANK_data_InBUS    = d;
        bus.SC_RegLANEBANK_load_InLow    = 1'b0;
        tick();
        bus.SC_RegLANEBANK_load_InLow    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.SC_RegLANEBANK_data_OutBUS !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data got %h exp %h", bus.SC_RegLANEBANK_data_OutBUS, 32'h0);
        end
        n_checks++;
        if (bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_stepped got %b exp %b", bus.SC_RegLANEBANK_stepped_Out, 4'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_clear();
        bus.SC_RegLANEBANK_clear_InLow = 1'b0;
        tick();
        bus.SC_RegLANEBANK_clear_InLow = 1'b1;
        n_checks++;
        if (bus.SC_RegLANEBANK_data_OutBUS !== {4{INIT}}) begin
            n_errors++;
            $display("FAIL clear_init got %h exp %h", bus.SC_RegLANEBANK_data_OutBUS, {4{INIT}});
        end
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp_l [3];
        exp_l[0] = 8'h03; exp_l[1] = 8'h06; exp_l[2] = 8'h0C;
        bus.SC_RegLANEBANK_period_InBUS = 16'h0100;
        bus.SC_RegLANEBANK_direction_In = 4'b0000;
        load_lane(2'd2, 8'h81);
        n_checks++;
        if (lane(2) !== 8'h81 || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL rotl_load got %h/%b exp 81/0000", lane(2), bus.SC_RegLANEBANK_stepped_Out);
        end
        bus.SC_RegLANEBANK_enable_In = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (lane(2) !== exp_l[k] || bus.SC_RegLANEBANK_stepped_Out !== 4'b0100) begin
                n_errors++;
                $display("FAIL rotl_step%0d got %h/%b exp %h/0100", k, lane(2),
                         bus.SC_RegLANEBANK_stepped_Out, exp_l[k]);
            end
        end
        bus.SC_RegLANEBANK_enable_In = 1'b0;
        tick();
        n_checks++;
        if (lane(2) !== 8'h0C || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL rotl_hold got %h/%b exp 0c/0000", lane(2), bus.SC_RegLANEBANK_stepped_Out);
        end
        n_checks++;
        if (lane(0) !== INIT || lane(1) !== INIT || lane(3) !== INIT) begin
            n_errors++;
            $display("FAIL rotl_others got %h exp %h", bus.SC_RegLANEBANK_data_OutBUS, INIT);
        end
    endtask

    task automatic test_rotate_right();
        logic [7:0] exp_d [6];
        logic       exp_s [6];
        exp_d[0] = 8'h01; exp_d[1] = 8'h01; exp_d[2] = 8'h80;
        exp_d[3] = 8'h80; exp_d[4] = 8'h80; exp_d[5] = 8'h40;
        exp_s[0] = 0; exp_s[1] = 0; exp_s[2] = 1; exp_s[3] = 0; exp_s[4] = 0; exp_s[5] = 1;
        bus.SC_RegLANEBANK_period_InBUS = 16'h0003;
        bus.SC_RegLANEBANK_direction_In = 4'b0001;
        load_lane(2'd0, 8'h01);
        bus.SC_RegLANEBANK_enable_In = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (lane(0) !== exp_d[k] || bus.SC_RegLANEBANK_stepped_Out !== {3'b000, exp_s[k]}) begin
                n_errors++;
                $display("FAIL rotr_cyc%0d got %h/%b exp %h/%b", k + 1, lane(0),
                         bus.SC_RegLANEBANK_stepped_Out, exp_d[k], {3'b000, exp_s[k]});
            end
        end
        bus.SC_RegLANEBANK_enable_In = 1'b0;
    endtask

    task automatic test_freeze();
        bus.SC_RegLANEBANK_period_InBUS = 16'h0000;
        bus.SC_RegLANEBANK_direction_In = 4'b0000;
        load_lane(2'd1, 8'h3C);
        bus.SC_RegLANEBANK_enable_In = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (lane(1) !== 8'h3C || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
                n_errors++;
                $display("FAIL freeze_cyc%0d got %h/%b exp 3c/0000", k, lane(1),
                         bus.SC_RegLANEBANK_stepped_Out);
            end
        end
        // A held-at-zero counter means P=2 needs two enables before the first rotation.
        bus.SC_RegLANEBANK_period_InBUS = 16'h0020;
        tick();
        n_checks++;
        if (lane(1) !== 8'h3C || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL freeze_cnt0 got %h/%b exp 3c/0000", lane(1), bus.SC_RegLANEBANK_stepped_Out);
        end
        tick();
        n_checks++;
        if (lane(1) !== 8'h78 || bus.SC_RegLANEBANK_stepped_Out !== 4'b0010) begin
            n_errors++;
            $display("FAIL freeze_resume got %h/%b exp 78/0010", lane(1), bus.SC_RegLANEBANK_stepped_Out);
        end
        bus.SC_RegLANEBANK_enable_In = 1'b0;
    endtask

    task automatic test_period_shrink();
        bus.SC_RegLANEBANK_period_InBUS = 16'h8000;
        bus.SC_RegLANEBANK_direction_In = 4'b0000;
        load_lane(2'd3, 8'h11);
        bus.SC_RegLANEBANK_enable_In = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (lane(3) !== 8'h11 || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL shrink_pre got %h/%b exp 11/0000", lane(3), bus.SC_RegLANEBANK_stepped_Out);
        end
        bus.SC_RegLANEBANK_period_InBUS = 16'h2000;
        tick();
        n_checks++;
        if (lane(3) !== 8'h22 || bus.SC_RegLANEBANK_stepped_Out !== 4'b1000) begin
            n_errors++;
            $display("FAIL shrink_fire got %h/%b exp 22/1000", lane(3), bus.SC_RegLANEBANK_stepped_Out);
        end
        tick();
        n_checks++;
        if (lane(3) !== 8'h22 || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL shrink_cnt0 got %h/%b exp 22/0000", lane(3), bus.SC_RegLANEBANK_stepped_Out);
        end
        tick();
        n_checks++;
        if (lane(3) !== 8'h44 || bus.SC_RegLANEBANK_stepped_Out !== 4'b1000) begin
            n_errors++;
            $display("FAIL shrink_next got %h/%b exp 44/1000", lane(3), bus.SC_RegLANEBANK_stepped_Out);
        end
        bus.SC_RegLANEBANK_enable_In = 1'b0;
    endtask

    task automatic test_load_collision();
        bus.SC_RegLANEBANK_period_InBUS = 16'h0022;
        bus.SC_RegLANEBANK_direction_In = 4'b0000;
        load_lane(2'd0, 8'h01);
        load_lane(2'd1, 8'h10);
        bus.SC_RegLANEBANK_enable_In = 1'b1;
        tick();
        bus.SC_RegLANEBANK_laneselect_In = 2'd1;
        bus.SC_RegLANEBANK_data_InBUS    = 8'hF0;
        bus.SC_RegLANEBANK_load_InLow    = 1'b0;
        tick();
        bus.SC_RegLANEBANK_load_InLow    = 1'b1;
        bus.SC_RegLANEBANK_enable_In     = 1'b0;
        n_checks++;
        if (lane(1) !== 8'hF0 || lane(0) !== 8'h02) begin
            n_errors++;
            $display("FAIL collide_data got l1=%h l0=%h exp f0/02", lane(1), lane(0));
        end
        n_checks++;
        if (bus.SC_RegLANEBANK_stepped_Out !== 4'b0001) begin
            n_errors++;
            $display("FAIL collide_stepped got %b exp 0001", bus.SC_RegLANEBANK_stepped_Out);
        end
    endtask

    task automatic test_priority();
        bus.SC_RegLANEBANK_period_InBUS  = 16'h1111;
        bus.SC_RegLANEBANK_enable_In     = 1'b1;
        bus.SC_RegLANEBANK_clear_InLow   = 1'b0;
        bus.SC_RegLANEBANK_load_InLow    = 1'b0;
        bus.SC_RegLANEBANK_laneselect_In = 2'd0;
        bus.SC_RegLANEBANK_data_InBUS    = 8'hFF;
        tick();
        n_checks++;
        if (bus.SC_RegLANEBANK_data_OutBUS !== {4{INIT}} || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL clear_over_load got %h/%b exp %h/0000", bus.SC_RegLANEBANK_data_OutBUS,
                     bus.SC_RegLANEBANK_stepped_Out, {4{INIT}});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.SC_RegLANEBANK_clear_InLow = 1'b1;
        bus.SC_RegLANEBANK_load_InLow  = 1'b1;
        bus.SC_RegLANEBANK_enable_In   = 1'b0;
        n_checks++;
        if (bus.SC_RegLANEBANK_data_OutBUS !== 32'h0 || bus.SC_RegLANEBANK_stepped_Out !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_over_clear got %h/%b exp 0/0000", bus.SC_RegLANEBANK_data_OutBUS,
                     bus.SC_RegLANEBANK_stepped_Out);
        end
    endtask

    task automatic test_reset_sync();
        load_lane(2'd0, 8'h5A);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if (lane(0) !== 8'h5A) begin
            n_errors++;
            $display("FAIL reset_glitch got %h exp 5a", lane(0));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.SC_RegLANEBANK_clear_InLow   = 1'b1;
        bus.SC_RegLANEBANK_load_InLow    = 1'b1;
        bus.SC_RegLANEBANK_laneselect_In = '0;
        bus.SC_RegLANEBANK_data_InBUS    = '0;
        bus.SC_RegLANEBANK_enable_In     = 1'b0;
        bus.SC_RegLANEBANK_direction_In  = '0;
        bus.SC_RegLANEBANK_period_InBUS  = '0;
        test_reset();
        test_clear();
        test_rotate_left();
        test_rotate_right();
        test_freeze();
        test_period_shrink();
        test_load_collision();
        test_priority();
        test_reset_sync();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
